// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS pipeline fetch slice.
//   fetch_state_t : IF-stage fetch FSM state
//   NOP_INSTR     : instruction word held in D while it carries a bubble
//   OP_J          : opcode of the j instruction
//   jump_target   : pseudo-direct j target formed from pc+4 and the instruction word
package mips_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StDrop,
    StFull
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  localparam logic [5:0]  OP_J      = 6'h02;

  function automatic logic [31:0] jump_target(input logic [31:0] pc_plus4,
                                              input logic [31:0] instr);
    return {pc_plus4[31:28], instr[25:0], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory fetch bus.
//   req   : fetch request valid (fetch side)
//   addr  : fetch address, stable while req is high and ack has not arrived
//   ack   : one-cycle pulse, rdata valid and transaction complete (memory side)
//   rdata : fetched instruction word
// Modports: master = fetch stage, slave = instruction memory.
interface fetch_stage_if;
  logic        req;
  logic [31:0] addr;
  logic        ack;
  logic [31:0] rdata;

  modport master (
    output req,
    output addr,
    input  ack,
    input  rdata
  );

  modport slave (
    input  req,
    input  addr,
    output ack,
    output rdata
  );
endinterface

// File: rtl/flopenrc.sv
// Enable/clear register with asynchronous active-high reset.
//   clk, reset : clock and asynchronous reset (reset value is zero)
//   en_i       : load enable; when low the register holds, clr_i included
//   clr_i      : synchronous clear, only acts when enabled
//   d_i / q_o  : data in / registered data out
module flopenrc #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en_i,
  input  logic             clr_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] q_d, q_q;

  always_comb begin
    q_d = q_q;
    if (en_i) begin
      q_d = clr_i ? '0 : d_i;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/fetch_stage.sv
// IF stage plus IF/ID pipeline register.
// Owns pcF, fetches over a req/ack bus of variable latency, and presents the fetched
// instruction to ID. Applies branch/jump redirects resolved in ID, inserts bubbles and
// honours the ID hazard stall.
//   clk, reset      : clock, asynchronous active-high reset
//   stallD          : ID hazard stall; IF/ID holds and F is held with it
//   pcsrcD, jumpD   : taken branch / jump in ID
//   pcbranchD       : branch target from ID
//   imem            : fetch bus (master side)
//   instrD          : IF/ID instruction, zero when bubble
//   pcplus4D        : IF/ID pc+4
//   opD, functD     : opcode and funct fields of instrD
//   validD          : instrD holds a real instruction
module fetch_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 stallD,
  input  logic                 pcsrcD,
  input  logic                 jumpD,
  input  logic [31:0]          pcbranchD,
  fetch_stage_if.master        imem,
  output logic [31:0]          instrD,
  output logic [31:0]          pcplus4D,
  output logic [5:0]           opD,
  output logic [5:0]           functD,
  output logic                 validD
);

  fetch_state_t state_d, state_q;
  logic [31:0]  pc_d, pc_q;
  logic [31:0]  buf_d, buf_q;
  logic [31:0]  target_d, target_q;
  logic         req_d, req_q;

  logic [31:0]  pc_plus4;
  logic         redirect;
  logic [31:0]  target;

  // IF/ID load path
  logic         load;
  logic [31:0]  load_instr;
  logic [31:0]  load_pc4;
  logic         bubble;

  assign pc_plus4 = pc_q + 32'd4;
  assign redirect = validD & ~stallD & (pcsrcD | jumpD);
  assign target   = pcsrcD ? pcbranchD : jump_target(pcplus4D, instrD);

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    buf_d      = buf_q;
    target_d   = target_q;
    load       = 1'b0;
    load_instr = imem.rdata;
    load_pc4   = pc_plus4;

    unique case (state_q)
      StIdle: begin
        state_d = StReq;
      end
      StReq: begin
        if (imem.ack) begin
          if (stallD) begin
            // D is held: park the word in the skid buffer and stop fetching.
            buf_d   = imem.rdata;
            pc_d    = pc_plus4;
            state_d = StFull;
          end else if (redirect) begin
            // Fetched word is on the wrong path; drop it and retarget.
            pc_d = target;
          end else begin
            load = 1'b1;
            pc_d = pc_plus4;
          end
        end else if (redirect) begin
          // Transaction already launched at the old pc; must complete it before retargeting.
          target_d = target;
          state_d  = StDrop;
        end
      end
      StDrop: begin
        if (imem.ack) begin
          pc_d    = target_q;
          state_d = StReq;
        end
      end
      StFull: begin
        if (!stallD) begin
          state_d = StReq;
          if (redirect) begin
            pc_d = target;
          end else begin
            // pc_q already advanced past the buffered word, so it is that word's pc+4.
            load       = 1'b1;
            load_instr = buf_q;
            load_pc4   = pc_q;
          end
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    req_d = (state_d == StReq) || (state_d == StDrop);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      pc_q     <= RESET_PC;
      buf_q    <= NOP_INSTR;
      target_q <= '0;
      req_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      buf_q    <= buf_d;
      target_q <= target_d;
      req_q    <= req_d;
    end
  end

  assign imem.req  = req_q;
  assign imem.addr = pc_q;

  // Every unstalled cycle either loads a real instruction or writes a bubble.
  assign bubble = ~load;

  flopenrc #(.WIDTH(32)) u_instr_d (
    .clk   (clk),
    .reset (reset),
    .en_i  (~stallD),
    .clr_i (bubble),
    .d_i   (load_instr),
    .q_o   (instrD)
  );

  flopenrc #(.WIDTH(32)) u_pcplus4_d (
    .clk   (clk),
    .reset (reset),
    .en_i  (~stallD),
    .clr_i (bubble),
    .d_i   (load_pc4),
    .q_o   (pcplus4D)
  );

  flopenrc #(.WIDTH(1)) u_valid_d (
    .clk   (clk),
    .reset (reset),
    .en_i  (~stallD),
    .clr_i (bubble),
    .d_i   (1'b1),
    .q_o   (validD)
  );

  assign opD    = instrD[31:26];
  assign functD = instrD[5:0];

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage. Stimulus pushes each instruction expected to reach D
// into a queue; an independent monitor pops and compares on every new delivery, flags any
// delivery with an empty queue, and checks bus address stability and bubble encoding.
module tb_fetch_stage;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        stallD;
  logic        pcsrcD;
  logic        jumpD;
  logic [31:0] pcbranchD;
  logic [31:0] instrD;
  logic [31:0] pcplus4D;
  logic [5:0]  opD;
  logic [5:0]  functD;
  logic        validD;

  fetch_stage_if imem_bus ();

  fetch_stage #(.RESET_PC(RST_PC)) dut (
    .clk       (clk),
    .reset     (reset),
    .stallD    (stallD),
    .pcsrcD    (pcsrcD),
    .jumpD     (jumpD),
    .pcbranchD (pcbranchD),
    .imem      (imem_bus),
    .instrD    (instrD),
    .pcplus4D  (pcplus4D),
    .opD       (opD),
    .functD    (functD),
    .validD    (validD)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_instr(input logic [31:0] instr, input logic [31:0] pc4);
    exp_t e;
    e.instr = instr;
    e.pc4   = pc4;
    exp_q.push_back(e);
  endtask

  // Monitor
  logic        last_stall = 1'b0;
  logic        prev_req   = 1'b0;
  logic        prev_ack   = 1'b0;
  logic [31:0] prev_addr  = '0;

  always @(posedge clk) last_stall <= stallD;

  always @(negedge clk) begin
    if (!reset) begin
      if (!validD) begin
        chk("bubble_instr_zero", instrD, 32'h0);
      end else if (!last_stall) begin
        // D was enabled at the last edge and is valid: a new delivery.
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_delivery: got instr %h pc4 %h, required none",
                   instrD, pcplus4D);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("deliv_instr", instrD, e.instr);
          chk("deliv_pc4", pcplus4D, e.pc4);
          chk("deliv_op", {26'h0, opD}, {26'h0, e.instr[31:26]});
          chk("deliv_funct", {26'h0, functD}, {26'h0, e.instr[5:0]});
        end
      end
      if (prev_req && !prev_ack && imem_bus.req) begin
        chk("addr_stable", imem_bus.addr, prev_addr);
      end
    end
    prev_req  = imem_bus.req && !reset;
    prev_ack  = imem_bus.ack;
    prev_addr = imem_bus.addr;
  end

  initial begin
    reset          = 1'b1;
    stallD         = 1'b0;
    pcsrcD         = 1'b0;
    jumpD          = 1'b0;
    pcbranchD      = '0;
    imem_bus.ack   = 1'b0;
    imem_bus.rdata = '0;
    #1;
    chk("rst_req", {31'h0, imem_bus.req}, 32'h0);
    chk("rst_valid", {31'h0, validD}, 32'h0);
    chk("rst_instr", instrD, 32'h0);
    chk("rst_pc4", pcplus4D, 32'h0);
    chk("rst_addr", imem_bus.addr, RST_PC);
    step();
    step();
    reset = 1'b0;

    // 1: first fetch, ack one cycle after req rises
    step();
    chk("t1_req", {31'h0, imem_bus.req}, 32'h1);
    chk("t1_addr0", imem_bus.addr, 32'h0);
    step();
    chk("t1_no_ack_bubble", {31'h0, validD}, 32'h0);
    imem_bus.ack   = 1'b1;
    imem_bus.rdata = 32'h8C01_0004;
    expect_instr(32'h8C01_0004, 32'h4);
    step();
    chk("t1_instr", instrD, 32'h8C01_0004);
    chk("t1_op", {26'h0, opD}, 32'h23);
    chk("t1_pc4", pcplus4D, 32'h4);
    chk("t1_valid", {31'h0, validD}, 32'h1);
    chk("t1_next_addr", imem_bus.addr, 32'h4);

    // 2: stall at ack for addr 8 -> skid buffer
    imem_bus.rdata = 32'h0022_1820;
    expect_instr(32'h0022_1820, 32'h8);
    step();
    imem_bus.rdata = 32'hAC22_0008;
    stallD         = 1'b1;
    step();
    imem_bus.ack = 1'b0;
    chk("t2_full_req", {31'h0, imem_bus.req}, 32'h0);
    chk("t2_held_instr", instrD, 32'h0022_1820);
    step();
    chk("t2_full_req2", {31'h0, imem_bus.req}, 32'h0);
    chk("t2_held_pc4", pcplus4D, 32'h8);
    stallD = 1'b0;
    expect_instr(32'hAC22_0008, 32'hC);
    step();
    chk("t2_buf_instr", instrD, 32'hAC22_0008);
    chk("t2_buf_pc4", pcplus4D, 32'hC);
    chk("t2_req", {31'h0, imem_bus.req}, 32'h1);
    chk("t2_addr", imem_bus.addr, 32'hC);

    // 3: branch redirect while request to 0x10 pending -> DROP
    imem_bus.ack   = 1'b1;
    imem_bus.rdata = 32'h1022_000F;
    expect_instr(32'h1022_000F, 32'h10);
    step();
    imem_bus.ack = 1'b0;
    chk("t3_addr", imem_bus.addr, 32'h10);
    pcsrcD    = 1'b1;
    pcbranchD = 32'h40;
    step();
    pcsrcD = 1'b0;
    chk("t3_drop_valid", {31'h0, validD}, 32'h0);
    chk("t3_drop_addr", imem_bus.addr, 32'h10);
    chk("t3_drop_req", {31'h0, imem_bus.req}, 32'h1);
    step();
    chk("t3_drop_addr2", imem_bus.addr, 32'h10);
    imem_bus.ack   = 1'b1;
    imem_bus.rdata = 32'hDEAD_BEEF;
    step();
    imem_bus.ack = 1'b0;
    chk("t3_target_addr", imem_bus.addr, 32'h40);
    chk("t3_valid", {31'h0, validD}, 32'h0);
    step();
    chk("t3_valid2", {31'h0, validD}, 32'h0);

    // 4: jump in D, no ack -> DROP, then fetch from jump target
    imem_bus.ack   = 1'b1;
    imem_bus.rdata = 32'h0800_0030;
    expect_instr(32'h0800_0030, 32'h44);
    step();
    imem_bus.ack = 1'b0;
    jumpD        = 1'b1;
    step();
    jumpD = 1'b0;
    chk("t4_drop_addr", imem_bus.addr, 32'h44);
    chk("t4_valid", {31'h0, validD}, 32'h0);
    imem_bus.ack   = 1'b1;
    imem_bus.rdata = 32'h1111_1111;
    step();
    chk("t4_target_addr", imem_bus.addr, 32'hC0);

    // 5: redirect and ack in the same cycle
    imem_bus.rdata = 32'h0800_0004;
    expect_instr(32'h0800_0004, 32'hC4);
    step();
    jumpD          = 1'b1;
    imem_bus.rdata = 32'h2222_2222;
    step();
    jumpD        = 1'b0;
    imem_bus.ack = 1'b0;
    chk("t5_addr", imem_bus.addr, 32'h10);
    chk("t5_req", {31'h0, imem_bus.req}, 32'h1);
    chk("t5_valid", {31'h0, validD}, 32'h0);
    imem_bus.ack   = 1'b1;
    imem_bus.rdata = 32'h8C03_0008;
    expect_instr(32'h8C03_0008, 32'h14);
    step();
    chk("t5_instr", instrD, 32'h8C03_0008);
    chk("t5_next_addr", imem_bus.addr, 32'h14);

    // Redirect while the skid buffer is full: buffer discarded
    imem_bus.rdata = 32'h3333_3333;
    stallD         = 1'b1;
    step();
    imem_bus.ack = 1'b0;
    chk("full_req", {31'h0, imem_bus.req}, 32'h0);
    stallD    = 1'b0;
    pcsrcD    = 1'b1;
    pcbranchD = 32'h80;
    step();
    pcsrcD = 1'b0;
    chk("full_redir_addr", imem_bus.addr, 32'h80);
    chk("full_redir_valid", {31'h0, validD}, 32'h0);

    // pc+4 wraps from 0xFFFF_FFFC to 0
    imem_bus.ack   = 1'b1;
    imem_bus.rdata = 32'h1000_0001;
    expect_instr(32'h1000_0001, 32'h84);
    step();
    imem_bus.ack = 1'b0;
    pcsrcD       = 1'b1;
    pcbranchD    = 32'hFFFF_FFFC;
    step();
    pcsrcD         = 1'b0;
    imem_bus.ack   = 1'b1;
    imem_bus.rdata = 32'h4444_4444;
    step();
    chk("wrap_addr", imem_bus.addr, 32'hFFFF_FFFC);
    imem_bus.rdata = 32'h0000_0020;
    expect_instr(32'h0000_0020, 32'h0);
    step();
    chk("wrap_pc4", pcplus4D, 32'h0);
    chk("wrap_next_addr", imem_bus.addr, 32'h0);
    chk("wrap_valid", {31'h0, validD}, 32'h1);

    // 6: reset asserted mid-DROP
    imem_bus.rdata = 32'h1000_0002;
    expect_instr(32'h1000_0002, 32'h4);
    step();
    imem_bus.ack = 1'b0;
    pcsrcD       = 1'b1;
    pcbranchD    = 32'h200;
    step();
    pcsrcD = 1'b0;
    chk("t6_drop_addr", imem_bus.addr, 32'h4);
    chk("t6_drop_req", {31'h0, imem_bus.req}, 32'h1);
    #2;
    reset = 1'b1;
    #1;
    chk("t6_rst_req", {31'h0, imem_bus.req}, 32'h0);
    chk("t6_rst_addr", imem_bus.addr, RST_PC);
    chk("t6_rst_valid", {31'h0, validD}, 32'h0);
    chk("t6_rst_pc4", pcplus4D, 32'h0);
    step();
    step();
    reset = 1'b0;
    step();
    chk("t6_req", {31'h0, imem_bus.req}, 32'h1);
    chk("t6_addr", imem_bus.addr, RST_PC);
    imem_bus.ack   = 1'b1;
    imem_bus.rdata = 32'h8C01_0004;
    expect_instr(32'h8C01_0004, 32'h4);
    step();
    imem_bus.ack = 1'b0;
    chk("t6_instr", instrD, 32'h8C01_0004);
    chk("t6_next_addr", imem_bus.addr, 32'h4);
    step();
    step();
    chk("all_delivered", exp_q.size(), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
